// File: rtl/neuron_act_collector_if.sv
// Handshake bundle between a neuron's sum output, the activation collector
// and the next layer's vector input.
//   in_valid/in_data/in_ready : one raw 4*WIDTH signed neuron sum per handshake
//   out_vec/out_valid/out_ready: completed 2*WIDTH activation vector
//   count                     : samples stored in the vector being built
// slave  = collector side, master = producer/consumer side.
interface neuron_act_collector_if #(
  parameter int OUT_SIZE = 32,
  parameter int WIDTH    = 8
);
  localparam int CW = $clog2(OUT_SIZE + 1);

  logic                                  in_valid;
  logic signed [4*WIDTH-1:0]             in_data;
  logic                                  in_ready;
  // Entry 0 is the first sample accepted; entries are always >= 0.
  logic        [0:OUT_SIZE-1][2*WIDTH-1:0] out_vec;
  logic                                  out_valid;
  logic                                  out_ready;
  logic        [CW-1:0]                  count;

  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_vec, out_valid, count);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_vec, out_valid, count);
endinterface

// File: rtl/neuron_act_collector.sv
// Activation collector: ReLU -> rounding right shift -> saturate to 2*WIDTH,
// gathered into an OUT_SIZE vector that is offered with valid/ready.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : neuron_act_collector_if.slave (input sample handshake, output
//           vector handshake, fill count)
module neuron_act_collector #(
  parameter int OUT_SIZE = 32,
  parameter int WIDTH    = 8,
  parameter int SHIFT    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  neuron_act_collector_if.slave   bus
);
  localparam int IW   = 4*WIDTH;
  localparam int OW   = 2*WIDTH;
  localparam int CW   = $clog2(OUT_SIZE + 1);
  localparam int IDXW = $clog2(OUT_SIZE);
  localparam int RS   = (SHIFT > 0) ? SHIFT - 1 : 0;
  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic [IW:0] RND = (SHIFT > 0) ? ((IW+1)'(1) << RS) : '0;
  // Largest positive 2*WIDTH signed value, held in the widened domain.
  localparam logic [IW:0] SAT = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                      state_q, state_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic [CW-1:0]               count_q, count_d;
  logic [0:OUT_SIZE-1][OW-1:0] vec_q;
  logic                        wr_en;

  // Activation. The sum is widened by one bit so the rounding add on a
  // maximal positive input cannot wrap; negatives never reach the shift.
  logic [IW:0]   sum_w, shr_w;
  logic [OW-1:0] act_w;

  always_comb begin
    sum_w = {1'b0, bus.in_data} + RND;
    shr_w = sum_w >> SHIFT;
    act_w = shr_w[OW-1:0];
    if (bus.in_data[IW-1])  act_w = '0;
    else if (shr_w > SAT)   act_w = SAT[OW-1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    wr_en   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (bus.in_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          if (idx_q == IDXW'(OUT_SIZE-1)) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d   = idx_q + IDXW'(1);
          end
        end
      end
      HOLD: begin
        // Vector stays frozen; inputs are refused until the consumer takes it.
        if (bus.out_ready) begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Entries persist across vectors until overwritten one by one.
  always_ff @(posedge clk) begin
    if (reset)      vec_q        <= '0;
    else if (wr_en) vec_q[idx_q] <= act_w;
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_vec   = vec_q;
  assign bus.count     = count_q;
endmodule
